tdm_demux14: RTL and testbench

//  Serial-to-parallel 1:4 time-division demultiplexer: receive end of a
//  4-channel TDM link whose transmitter selects one channel at a time.

---
 rtl/tdm_demux14.sv | 125 ++++++++++++
 tb/tb_tdm_demux14.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/tdm_demux14.sv
// 1:4 TDM serial-to-parallel demultiplexer. It recovers four WIDTH-bit channel
// words, MSB first, from a serial stream that is aligned to a frame SYNC marker.
module tdm_demux14 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               din,
  input  logic               sync,
  output logic [4*WIDTH-1:0] out,
  output logic [1:0]         sel_out,
  output logic [3:0]         ch_vld,
  output logic               frame_vld,
  output logic               lock,
  output logic               sync_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   sr, sr_n;
  logic [CW-1:0]      bit_cnt, bit_cnt_n;
  logic [1:0]         ch, ch_n;
  logic [4*WIDTH-1:0] out_n;
  logic [3:0]         ch_vld_n;
  logic               frame_vld_n;
  logic               sync_err_n;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   first_bit;

  assign shifted   = {sr[WIDTH-2:0], din};
  assign first_bit = {{(WIDTH-1){1'b0}}, din};
  assign sel_out   = ch;

  // Next-state, datapath and pulse decode; pulses default low so EN=0 cycles drop them
  always_comb begin
    state_n     = state;
    sr_n        = sr;
    bit_cnt_n   = bit_cnt;
    ch_n        = ch;
    out_n       = out;
    ch_vld_n    = 4'b0000;
    frame_vld_n = 1'b0;
    sync_err_n  = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          if (sync) begin
            sr_n      = first_bit;
            bit_cnt_n = CW'(1);
            ch_n      = 2'd0;
            state_n   = LOCKED;
          end else begin
            state_n = HUNT;
          end
        end
        LOCKED: begin
          if ((bit_cnt == '0) && (ch == 2'd0)) begin
            // A frame boundary: SYNC is mandatory here, so a missing one drops lock
            if (sync) begin
              sr_n      = first_bit;
              bit_cnt_n = CW'(1);
            end else begin
              sync_err_n = 1'b1;
              state_n    = HUNT;
            end
          end else if (sync) begin
            sync_err_n = 1'b1;
            sr_n       = first_bit;
            bit_cnt_n  = CW'(1);
            ch_n       = 2'd0;
          end else if (bit_cnt == LAST_BIT) begin
            sr_n                           = shifted;
            out_n[int'(ch)*WIDTH +: WIDTH] = shifted;
            ch_vld_n                       = 4'b0001 << ch;
            frame_vld_n                    = (ch == 2'd3);
            bit_cnt_n                      = '0;
            ch_n                           = ch + 2'd1;
          end else begin
            sr_n      = shifted;
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end
        default: begin
          state_n = HUNT;
        end
      endcase
    end else begin
      state_n = state;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sr        <= '0;
      bit_cnt   <= '0;
      ch        <= 2'd0;
      out       <= '0;
      ch_vld    <= 4'b0000;
      frame_vld <= 1'b0;
      lock      <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      bit_cnt   <= bit_cnt_n;
      ch        <= ch_n;
      out       <= out_n;
      ch_vld    <= ch_vld_n;
      frame_vld <= frame_vld_n;
      lock      <= (state_n == LOCKED);
      sync_err  <= sync_err_n;
    end
  end

endmodule

// File: tb/tb_tdm_demux14.sv
// Table-driven bench for tdm_demux14 (WIDTH=8). Each vector holds one bit slot
// and the outputs expected after the next rising edge.
module tb_tdm_demux14;

  logic        clk = 1'b0;
  logic        rst_n, en, din, sync;
  logic [31:0] out;
  logic [1:0]  sel_out;
  logic [3:0]  ch_vld;
  logic        frame_vld, lock, sync_err;

  tdm_demux14 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .sync(sync),
    .out(out), .sel_out(sel_out), .ch_vld(ch_vld), .frame_vld(frame_vld),
    .lock(lock), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, din, sync;
    logic [3:0]  chv;
    logic        fv, lk, serr;
    logic [1:0]  sel;
    logic [31:0] out;
    string       name;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] exp_out;
  int          nvec;
  int          nerr;

  task automatic push(input logic e, input logic d, input logic s, input logic [3:0] chv,
                      input logic fv, input logic lk, input logic se, input logic [1:0] sel,
                      input string nm);
    vec_t v;
    v.en = e; v.din = d; v.sync = s; v.chv = chv; v.fv = fv; v.lk = lk;
    v.serr = se; v.sel = sel; v.out = exp_out; v.name = nm;
    vq.push_back(v);
  endtask

  // One channel word. The LSB slot pulses CH_VLD[c] and advances SEL_OUT.
  task automatic send_word(input logic [7:0] b, input int c, input bit with_sync,
                           input bit err_first, input bit gaps, input string nm);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] chv;
      logic       fv;
      logic [1:0] sel;
      chv = 4'b0000; fv = 1'b0; sel = 2'(c);
      if (i == 7) begin
        exp_out[c*8 +: 8] = b;
        chv = 4'b0001 << c;
        fv  = (c == 3);
        sel = 2'(c + 1);
      end
      push(1'b1, b[7-i], 1'(with_sync && i == 0), chv, fv, 1'b1, 1'(err_first && i == 0), sel, nm);
      if (gaps) push(1'b0, 1'(i % 2), 1'(i == 3), 4'b0000, 1'b0, 1'b1, 1'b0, sel, {nm, "_gap"});
    end
  endtask

  task automatic check(input string nm, input logic [3:0] chv, input logic fv, input logic lk,
                       input logic se, input logic [1:0] sel, input logic [31:0] o);
    nvec++;
    if (ch_vld !== chv || frame_vld !== fv || lock !== lk || sync_err !== se ||
        sel_out !== sel || out !== o) begin
      nerr++;
      $display("FAIL %s: got ch_vld=%b frame_vld=%b lock=%b sync_err=%b sel=%0d out=%h, want ch_vld=%b frame_vld=%b lock=%b sync_err=%b sel=%0d out=%h",
               nm, ch_vld, frame_vld, lock, sync_err, sel_out, out, chv, fv, lk, se, sel, o);
    end
  endtask

  initial begin
    logic [7:0] f2 [4];
    rst_n = 1'b0; en = 1'b0; din = 1'b0; sync = 1'b0;
    exp_out = 32'h0; nvec = 0; nerr = 0;
    f2[0] = 8'hA5; f2[1] = 8'h3C; f2[2] = 8'h0F; f2[3] = 8'hF0;
    repeat (2) @(negedge clk);
    check("reset_state", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    rst_n = 1'b1;

    // HUNT ignores data without SYNC
    for (int i = 0; i < 5; i++) push(1'b1, 1'(i % 2), 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "hunt_idle");
    // Clean frame, EN always high
    for (int c = 0; c < 4; c++) send_word(f2[c], c, c == 0, 1'b0, 1'b0, "clean");
    // Same frame with EN toggling
    for (int c = 0; c < 4; c++) send_word(f2[c], c, c == 0, 1'b0, 1'b1, "en_toggle");
    // Two back-to-back frames
    send_word(8'h11, 0, 1'b1, 1'b0, 1'b0, "b2b_a"); send_word(8'h22, 1, 1'b0, 1'b0, 1'b0, "b2b_a");
    send_word(8'h33, 2, 1'b0, 1'b0, 1'b0, "b2b_a"); send_word(8'h44, 3, 1'b0, 1'b0, 1'b0, "b2b_a");
    send_word(8'h55, 0, 1'b1, 1'b0, 1'b0, "b2b_b"); send_word(8'h66, 1, 1'b0, 1'b0, 1'b0, "b2b_b");
    send_word(8'h77, 2, 1'b0, 1'b0, 1'b0, "b2b_b"); send_word(8'h88, 3, 1'b0, 1'b0, 1'b0, "b2b_b");
    // Early SYNC on 5th bit of channel 1
    send_word(8'h99, 0, 1'b1, 1'b0, 1'b0, "early_ch0");
    for (int i = 0; i < 4; i++) push(1'b1, 1'(i < 2), 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, "early_partial");
    send_word(8'h11, 0, 1'b1, 1'b1, 1'b0, "early_realign"); send_word(8'h22, 1, 1'b0, 1'b0, 1'b0, "early_realign");
    send_word(8'h33, 2, 1'b0, 1'b0, 1'b0, "early_realign"); send_word(8'h44, 3, 1'b0, 1'b0, 1'b0, "early_realign");
    // Missing SYNC at a frame boundary, then 31 ignored bits, then relock
    push(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, "missing_sync");
    for (int i = 0; i < 31; i++) push(1'b1, 1'(i % 3 == 0), 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "lost_hunt");
    send_word(8'hA1, 0, 1'b1, 1'b0, 1'b0, "relock"); send_word(8'hB2, 1, 1'b0, 1'b0, 1'b0, "relock");
    send_word(8'hC3, 2, 1'b0, 1'b0, 1'b0, "relock"); send_word(8'hD4, 3, 1'b0, 1'b0, 1'b0, "relock");

    foreach (vq[i]) begin
      @(negedge clk);
      en = vq[i].en; din = vq[i].din; sync = vq[i].sync;
      @(posedge clk);
      #1;
      check(vq[i].name, vq[i].chv, vq[i].fv, vq[i].lk, vq[i].serr, vq[i].sel, vq[i].out);
    end
    if (exp_out !== 32'hD4C3B2A1) begin
      nerr++;
      $display("FAIL table_final_out: got %h, want d4c3b2a1", exp_out);
    end

    // Mid-word asynchronous reset while locked
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b1; din = 1'b1; sync = 1'(i == 0);
      @(posedge clk);
      #1;
      check("pre_reset_lock", 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, exp_out);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; din = 1'(i % 2); sync = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_hunt", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
      @(negedge clk);
    end
    en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
